// File: rtl/branch_predictor_pkg.sv
// Shared CPU constants for the branch predictor: PC width, 2-bit counter
// encodings and the statistics saturation value.
package branch_predictor_pkg;

  localparam int PC_W = 16;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [PC_W-1:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Combinational next-state of a 2-bit saturating branch counter.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != ST) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != SNT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with tags and targets;
// combinational lookup on the fetch PC, training from ID-stage verdicts.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [PC_W-1:0] pc_i,
  output logic            prediction_o,
  output logic [PC_W-1:0] predtarget_o,
  output logic            hit_o,
  input  logic [PC_W-1:0] upd_pc_i,
  input  logic [PC_W-1:0] upd_target_i,
  input  logic            ifbranch_i,
  input  logic            prewrong_i,
  input  logic            precorrc_i,
  output logic [PC_W-1:0] stat_total_o,
  output logic [PC_W-1:0] stat_wrong_o
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = PC_W - IDX_W;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [1:0]        cnt_q    [ENTRIES];
  logic [PC_W-1:0]   target_q [ENTRIES];
  logic [PC_W-1:0]   total_q, total_d;
  logic [PC_W-1:0]   wrong_q, wrong_d;

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;

  logic              upd_en;
  logic              upd_hit;
  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic [1:0]        cnt_sat;
  logic [1:0]        cnt_d;
  logic [PC_W-1:0]   target_d;

  // Lookup sees registered contents only, so a same-cycle update is not bypassed.
  always_comb begin
    lk_idx       = pc_i[IDX_W-1:0];
    lk_tag       = pc_i[PC_W-1:IDX_W];
    hit_o        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    prediction_o = hit_o && cnt_q[lk_idx][1];
    predtarget_o = prediction_o ? target_q[lk_idx] : '0;
  end

  sat_counter2 u_sat (
    .cnt_i   (cnt_q[upd_idx]),
    .taken_i (ifbranch_i),
    .cnt_o   (cnt_sat)
  );

  // Both verdicts high is treated as a misprediction: it trains and counts as wrong.
  always_comb begin
    upd_en   = prewrong_i || precorrc_i;
    upd_idx  = upd_pc_i[IDX_W-1:0];
    upd_tag  = upd_pc_i[PC_W-1:IDX_W];
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    cnt_d    = upd_hit ? cnt_sat : (ifbranch_i ? WT : WNT);
    target_d = (!upd_hit || ifbranch_i) ? upd_target_i : target_q[upd_idx];
    total_d  = total_q;
    wrong_d  = wrong_q;
    if (upd_en && (total_q != STAT_MAX)) total_d = total_q + 16'd1;
    if (prewrong_i && (wrong_q != STAT_MAX)) wrong_d = wrong_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        cnt_q[i]    <= WNT;
        target_q[i] <= '0;
      end
      total_q <= '0;
      wrong_q <= '0;
    end else begin
      if (upd_en) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        cnt_q[upd_idx]    <= cnt_d;
        target_q[upd_idx] <= target_d;
      end
      total_q <= total_d;
      wrong_q <= wrong_d;
    end
  end

  assign stat_total_o = total_q;
  assign stat_wrong_o = wrong_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] pc_i;
  logic        prediction_o;
  logic [15:0] predtarget_o;
  logic        hit_o;
  logic [15:0] upd_pc_i;
  logic [15:0] upd_target_i;
  logic        ifbranch_i;
  logic        prewrong_i;
  logic        precorrc_i;
  logic [15:0] stat_total_o;
  logic [15:0] stat_wrong_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  branch_predictor #(.IDX_W(4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .pc_i         (pc_i),
    .prediction_o (prediction_o),
    .predtarget_o (predtarget_o),
    .hit_o        (hit_o),
    .upd_pc_i     (upd_pc_i),
    .upd_target_i (upd_target_i),
    .ifbranch_i   (ifbranch_i),
    .prewrong_i   (prewrong_i),
    .precorrc_i   (precorrc_i),
    .stat_total_o (stat_total_o),
    .stat_wrong_o (stat_wrong_o)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic look(input logic [15:0] pc);
    pc_i = pc;
    #1;
  endtask

  task automatic lookup(input string tag, input logic [15:0] pc,
                        input logic h, input logic p, input logic [15:0] t);
    look(pc);
    chk({tag, ".hit"},  {15'd0, hit_o}, {15'd0, h});
    chk({tag, ".pred"}, {15'd0, prediction_o}, {15'd0, p});
    chk({tag, ".tgt"},  predtarget_o, t);
  endtask

  task automatic stats(input string tag, input logic [15:0] tot, input logic [15:0] wr);
    chk({tag, ".total"}, stat_total_o, tot);
    chk({tag, ".wrong"}, stat_wrong_o, wr);
  endtask

  // One clock with the given update applied, then the update is withdrawn.
  task automatic upd(input logic [15:0] pc, input logic [15:0] tgt,
                     input logic br, input logic wr, input logic co);
    upd_pc_i     = pc;
    upd_target_i = tgt;
    ifbranch_i   = br;
    prewrong_i   = wr;
    precorrc_i   = co;
    @(posedge CLK);
    #1;
    prewrong_i = 1'b0;
    precorrc_i = 1'b0;
    ifbranch_i = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    pc_i = 16'h0000;
    upd_pc_i = 16'h0000;
    upd_target_i = 16'h0000;
    ifbranch_i = 1'b0;
    prewrong_i = 1'b0;
    precorrc_i = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    lookup("reset", 16'h0010, 1'b0, 1'b0, 16'h0000);
    stats("reset", 16'd0, 16'd0);

    // Allocate taken: cnt=10
    upd(16'h0013, 16'h0040, 1'b1, 1'b1, 1'b0);
    lookup("alloc", 16'h0013, 1'b1, 1'b1, 16'h0040);
    stats("alloc", 16'd1, 16'd1);

    // Not-taken x3: 01, 00, 00 (saturates)
    upd(16'h0013, 16'h0099, 1'b0, 1'b0, 1'b1);
    lookup("nt1", 16'h0013, 1'b1, 1'b0, 16'h0000);
    upd(16'h0013, 16'h0099, 1'b0, 1'b1, 1'b0);
    lookup("nt2", 16'h0013, 1'b1, 1'b0, 16'h0000);
    upd(16'h0013, 16'h0099, 1'b0, 1'b0, 1'b1);
    lookup("nt3", 16'h0013, 1'b1, 1'b0, 16'h0000);
    stats("nt3", 16'd4, 16'd2);

    // Taken: 00->01 (still NT), 01->10 (T, new target)
    upd(16'h0013, 16'h0050, 1'b1, 1'b0, 1'b1);
    lookup("t1", 16'h0013, 1'b1, 1'b0, 16'h0000);
    upd(16'h0013, 16'h0050, 1'b1, 1'b0, 1'b1);
    lookup("t2", 16'h0013, 1'b1, 1'b1, 16'h0050);

    // Saturate high: 10->11->11, then not-taken 11->10 still predicts taken
    upd(16'h0013, 16'h0050, 1'b1, 1'b0, 1'b1);
    upd(16'h0013, 16'h0050, 1'b1, 1'b0, 1'b1);
    upd(16'h0013, 16'h0077, 1'b0, 1'b1, 1'b0);
    lookup("sat_hi", 16'h0013, 1'b1, 1'b1, 16'h0050);
    stats("sat_hi", 16'd9, 16'd3);

    // Alias on index 3 with another tag, not taken
    upd(16'h0023, 16'h0070, 1'b0, 1'b1, 1'b0);
    lookup("alias_old", 16'h0013, 1'b0, 1'b0, 16'h0000);
    lookup("alias_new", 16'h0023, 1'b1, 1'b0, 16'h0000);
    stats("alias", 16'd10, 16'd4);

    // Same-cycle lookup and update: lookup sees pre-update contents
    pc_i = 16'h0005;
    upd_pc_i = 16'h0005;
    upd_target_i = 16'h0080;
    ifbranch_i = 1'b1;
    precorrc_i = 1'b1;
    #1;
    chk("same.hit_before", {15'd0, hit_o}, 16'd0);
    @(posedge CLK);
    #1;
    precorrc_i = 1'b0;
    ifbranch_i = 1'b0;
    lookup("same_after", 16'h0005, 1'b1, 1'b1, 16'h0080);
    stats("same", 16'd11, 16'd4);

    // Both verdicts high: trains (10->01) and counts as wrong
    upd(16'h0005, 16'h0081, 1'b0, 1'b1, 1'b1);
    lookup("both", 16'h0005, 1'b1, 1'b0, 16'h0000);
    stats("both", 16'd12, 16'd5);

    // Stall: no verdict -> nothing changes
    upd(16'h0006, 16'h0090, 1'b1, 1'b0, 1'b0);
    lookup("stall", 16'h0006, 1'b0, 1'b0, 16'h0000);
    stats("stall", 16'd12, 16'd5);

    // Reset concurrent with an update: update lost, table cleared
    RST = 1'b1;
    upd(16'h0007, 16'h00A0, 1'b1, 1'b1, 1'b0);
    RST = 1'b0;
    lookup("rst_upd", 16'h0007, 1'b0, 1'b0, 16'h0000);
    lookup("rst_old", 16'h0005, 1'b0, 1'b0, 16'h0000);
    stats("rst", 16'd0, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
